cga_mode_programmer: RTL and testbench
======================================

// Module: cga_mode_programmer
// PURPOSE
//  ISA I/O initiator that programs the CGA responder (0x3D4/3D5 CRTC, 0x3D8 mode, 0x3D9 colour) with one
//  of BIOS modes 0-6 from an internal ROM table, without a CPU. Used at boot and after splashscreen exit.
//  Shares the ISA bus with the CPU through a req/gnt arbiter; issues write cycles and optional 0x3DA polls.
// PARAMETERS
//  IO_BASE_ADDR  16'h3d0  CGA I/O base; targets base+4, +5, +8, +9, +A
//  STROBE_CYC    4        clocks iow_l/ior_l held low per cycle (min 2; CGA syncs strobes by one flop)
//  WAIT_VSYNC    1        1 = poll status bit3 (vsync) =1 before first write; 0 = skip poll
//  POLL_MAX      20'hFFFFF poll attempts before giving up
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  start       in   1   one-cycle request; sampled only in IDLE
//  mode_sel    in   3   BIOS mode 0-6; 7 = invalid
//  bus_req     out  1   bus request to arbiter
//  bus_gnt     in   1   grant; sampled every cycle
//  bus_a       out  15  I/O address
//  bus_d       out  8   write data
//  bus_in      in   8   read data (status register)
//  bus_iow_l   out  1   I/O write strobe, active low
//  bus_ior_l   out  1   I/O read strobe, active low
//  bus_aen     out  1   0 while this block owns an I/O cycle, else 1
//  busy        out  1   high from accepted start to done
//  done        out  1   one-cycle pulse at sequence end
//  error       out  1   sticky: invalid mode or poll timeout; cleared on next accepted start
// BEHAVIOUR
//  Reset: bus_req=0, bus_a=0, bus_d=0, bus_iow_l=1, bus_ior_l=1, bus_aen=1, busy=0, done=0, error=0; FSM IDLE.
//  Undriven rule: whenever no cycle is active, bus_a=0, bus_d=0, strobes=1, bus_aen=1.
//  FSM: IDLE->REQ->[POLL_SETUP->POLL_STB->POLL_EVAL]*->WR_SETUP->WR_STB->WR_HOLD->NEXT->...->DONE->IDLE.
//  IDLE: start & mode_sel<=6 -> busy=1, error=0, latch mode, REQ. start & mode_sel==7 -> error=1, done pulse, stay IDLE.
//  REQ: bus_req=1 (held until DONE); advance first cycle bus_gnt seen high.
//  Poll: SETUP 1 clk (a=base+A, aen=0), STB STROBE_CYC clks ior_l=0, bus_in sampled on last STB clk;
//   EVAL: bit3=1 -> writes; else count++, retry; count==POLL_MAX -> error=1, proceed to writes.
//  Write cycle: SETUP 1 clk (a,d valid, aen=0, iow_l=1), STB STROBE_CYC clks iow_l=0, HOLD 1 clk (a,d held, iow_l=1).
//  Write list (35 cycles, fixed order): 3D8<=modereg&~8'h08 (video off); for r=0..15: 3D4<=r, 3D5<=R[r];
//   3D9<=colour; 3D8<=modereg (video on). Write index is 6 bits, never wraps past 34.
//  Mode reg by mode 0..6: 2C 28 2D 29 2A 2E 1E; colour: 30 for 0-5, 3F for 6.
//  CRTC R0-R11 (R12-R15 = 0): 40-col text (0,1): 38 28 2D 0A 1F 06 19 1C 02 07 06 07;
//   80-col text (2,3): 71 50 5A 0A 1F 06 19 1C 02 07 06 07; graphics (4-6): 38 28 2D 0A 7F 06 64 70 02 01 06 07.
//  Latency, WAIT_VSYNC=0, gnt immediate: 35*(STROBE_CYC+2) clks from REQ to DONE (210 at default).
//  Grant loss: if bus_gnt=0 in any SETUP/STB/HOLD, next clk strobes=1, aen=1, a/d=0; return to REQ and
//   restart the interrupted access from SETUP; completed accesses are not repeated. Poll count kept.
//  DONE: 1 clk, done=1, bus_req=0, busy=0. start while busy ignored. reset mid-sequence: immediate reset values.
// TESTING
//  mode_sel=3, gnt tied 1, WAIT_VSYNC=0 -> 35 writes: 3D8=21, 3D4/3D5 R0=71..R9=07, 3D9=30, 3D8=29; done at cycle 210.
//  mode_sel=6 into CGA model -> CRTC R4=7F, R6=64; final control reg 1E; iow_l low exactly 4 clks per write.
//  WAIT_VSYNC=1, status bit3 goes 1 after 3 polls -> 4 reads of 3DA, then writes; error=0.
//  Poll with bit3 stuck 0, POLL_MAX=8 -> 8 polls, error=1, all 35 writes still issued, done pulses.
//  Drop gnt during STB of write 10 for 5 clks -> strobes released next clk, write 10 reissued, total 35 writes.
//  mode_sel=7 -> no bus_req, error=1, done one pulse; start during busy -> ignored, sequence unchanged.

Source files
------------

// File: rtl/cga_mode_programmer.sv
// rtl/cga_mode_programmer.sv - ISA I/O initiator that loads a BIOS mode (0-6) into a CGA responder.
// Optional vsync poll of the status port, then a fixed 35-write list (mode, 16 CRTC regs, colour, mode).
module cga_mode_programmer #(
  parameter logic [15:0] IO_BASE_ADDR = 16'h3d0,
  parameter int          STROBE_CYC   = 4,
  parameter bit          WAIT_VSYNC   = 1'b1,
  parameter logic [19:0] POLL_MAX     = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mode_sel,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [14:0] bus_a,
  output logic [7:0]  bus_d,
  input  logic [7:0]  bus_in,
  output logic        bus_iow_l,
  output logic        bus_ior_l,
  output logic        bus_aen,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] A_INDEX = IO_BASE_ADDR + 16'h0004;
  localparam logic [15:0] A_DATA  = IO_BASE_ADDR + 16'h0005;
  localparam logic [15:0] A_MODE  = IO_BASE_ADDR + 16'h0008;
  localparam logic [15:0] A_COL   = IO_BASE_ADDR + 16'h0009;
  localparam logic [15:0] A_STAT  = IO_BASE_ADDR + 16'h000a;
  localparam logic [7:0]  STB_LAST = 8'(STROBE_CYC - 1);
  localparam logic [5:0]  LAST_IDX = 6'd34;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_POLL_SETUP, S_POLL_STB, S_POLL_EVAL,
    S_WR_SETUP, S_WR_STB, S_WR_HOLD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  stb_q, stb_d;
  logic [19:0] poll_cnt_q, poll_cnt_d;
  logic        poll_done_q, poll_done_d;
  logic        vsync_q, vsync_d;
  logic [2:0]  mode_q, mode_d;
  logic        err_q, err_d;
  logic        inv_q, inv_d;

  logic [14:0] wr_a;
  logic [7:0]  wr_d;
  logic [5:0]  idx_m1;
  logic        unused_ok;

  function automatic logic [7:0] mode_reg(input logic [2:0] m);
    case (m)
      3'd0:    mode_reg = 8'h2c;
      3'd1:    mode_reg = 8'h28;
      3'd2:    mode_reg = 8'h2d;
      3'd3:    mode_reg = 8'h29;
      3'd4:    mode_reg = 8'h2a;
      3'd5:    mode_reg = 8'h2e;
      default: mode_reg = 8'h1e;
    endcase
  endfunction

  // Text modes differ only in horizontal timing (R0-R2); graphics differ in R4/R6/R7/R9.
  function automatic logic [7:0] crtc_val(input logic [2:0] m, input logic [3:0] r);
    logic t80, gfx;
    t80 = (m == 3'd2) || (m == 3'd3);
    gfx = (m >= 3'd4);
    case (r)
      4'd0:    crtc_val = t80 ? 8'h71 : 8'h38;
      4'd1:    crtc_val = t80 ? 8'h50 : 8'h28;
      4'd2:    crtc_val = t80 ? 8'h5a : 8'h2d;
      4'd3:    crtc_val = 8'h0a;
      4'd4:    crtc_val = gfx ? 8'h7f : 8'h1f;
      4'd5:    crtc_val = 8'h06;
      4'd6:    crtc_val = gfx ? 8'h64 : 8'h19;
      4'd7:    crtc_val = gfx ? 8'h70 : 8'h1c;
      4'd8:    crtc_val = 8'h02;
      4'd9:    crtc_val = gfx ? 8'h01 : 8'h07;
      4'd10:   crtc_val = 8'h06;
      4'd11:   crtc_val = 8'h07;
      default: crtc_val = 8'h00;
    endcase
  endfunction

  assign idx_m1    = idx_q - 6'd1;
  assign unused_ok = ^{bus_in[7:4], bus_in[2:0], idx_m1[5], A_INDEX[15], A_DATA[15],
                       A_MODE[15], A_COL[15], A_STAT[15]};

  always_comb begin
    wr_a = A_MODE[14:0];
    wr_d = mode_reg(mode_q) & 8'hf7;
    if (idx_q == LAST_IDX) begin
      wr_d = mode_reg(mode_q);
    end else if (idx_q == 6'd33) begin
      wr_a = A_COL[14:0];
      wr_d = (mode_q == 3'd6) ? 8'h3f : 8'h30;
    end else if (idx_q != 6'd0) begin
      wr_a = idx_m1[0] ? A_DATA[14:0] : A_INDEX[14:0];
      wr_d = idx_m1[0] ? crtc_val(mode_q, idx_m1[4:1]) : {4'h0, idx_m1[4:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      stb_q       <= '0;
      poll_cnt_q  <= '0;
      poll_done_q <= 1'b0;
      vsync_q     <= 1'b0;
      mode_q      <= '0;
      err_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stb_q       <= stb_d;
      poll_cnt_q  <= poll_cnt_d;
      poll_done_q <= poll_done_d;
      vsync_q     <= vsync_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      inv_q       <= inv_d;
    end
  end

  // HOLD advances the index directly, so every write costs exactly STROBE_CYC+2 clocks.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stb_d       = stb_q;
    poll_cnt_d  = poll_cnt_q;
    poll_done_d = poll_done_q;
    vsync_d     = vsync_q;
    mode_d      = mode_q;
    err_d       = err_q;
    inv_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode_sel == 3'd7) begin
            err_d = 1'b1;
            inv_d = 1'b1;
          end else begin
            err_d       = 1'b0;
            mode_d      = mode_sel;
            idx_d       = '0;
            poll_cnt_d  = '0;
            poll_done_d = !WAIT_VSYNC;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus_gnt) state_d = poll_done_q ? S_WR_SETUP : S_POLL_SETUP;
      end
      S_POLL_SETUP: begin
        stb_d   = '0;
        state_d = bus_gnt ? S_POLL_STB : S_REQ;
      end
      S_POLL_STB: begin
        if (!bus_gnt) begin
          state_d = S_REQ;
        end else if (stb_q == STB_LAST) begin
          vsync_d = bus_in[3];
          state_d = S_POLL_EVAL;
        end else begin
          stb_d = stb_q + 8'd1;
        end
      end
      S_POLL_EVAL: begin
        if (vsync_q) begin
          poll_done_d = 1'b1;
          state_d     = S_WR_SETUP;
        end else begin
          poll_cnt_d = poll_cnt_q + 20'd1;
          if (poll_cnt_q + 20'd1 == POLL_MAX) begin
            err_d       = 1'b1;
            poll_done_d = 1'b1;
            state_d     = S_WR_SETUP;
          end else begin
            state_d = S_POLL_SETUP;
          end
        end
      end
      S_WR_SETUP: begin
        stb_d   = '0;
        state_d = bus_gnt ? S_WR_STB : S_REQ;
      end
      S_WR_STB: begin
        if (!bus_gnt) state_d = S_REQ;
        else if (stb_q == STB_LAST) state_d = S_WR_HOLD;
        else stb_d = stb_q + 8'd1;
      end
      S_WR_HOLD: begin
        if (!bus_gnt) begin
          state_d = S_REQ;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_WR_SETUP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_a     = '0;
    bus_d     = '0;
    bus_iow_l = 1'b1;
    bus_ior_l = 1'b1;
    bus_aen   = 1'b1;
    case (state_q)
      S_POLL_SETUP, S_POLL_STB: begin
        bus_aen   = 1'b0;
        bus_a     = A_STAT[14:0];
        bus_ior_l = (state_q != S_POLL_STB);
      end
      S_WR_SETUP, S_WR_STB, S_WR_HOLD: begin
        bus_aen   = 1'b0;
        bus_a     = wr_a;
        bus_d     = wr_d;
        bus_iow_l = (state_q != S_WR_STB);
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus_req = busy;
  assign done    = (state_q == S_DONE) || inv_q;
  assign error   = err_q;

endmodule

// File: tb/tb_cga_mode_programmer.sv
// tb/tb_cga_mode_programmer.sv - randomized self-checking bench with a bus monitor and table-driven write model.
module tb_cga_mode_programmer;
  localparam int STB = 4;

  logic        clk = 1'b0;
  logic        reset, start, bus_gnt;
  logic [2:0]  mode_sel;
  logic [7:0]  bus_in, noise;
  logic        bus_req, bus_iow_l, bus_ior_l, bus_aen, busy, done, error;
  logic [14:0] bus_a;
  logic [7:0]  bus_d;

  int errors = 0, checks = 0;
  int cyc = 0, wr_len = 0, rd_len = 0, aborted = 0, reads_done = 0;
  int done_cnt = 0, done_cyc = 0, first_wr = -1, bad_aen = 0, bad_idle = 0, bad_hold = 0;
  int req_seen = 0, vsync_after = 0;
  logic [14:0] cur_a;
  logic [7:0]  cur_d;
  logic [22:0] wr_q[$];
  logic [22:0] exp_q[$];

  logic [7:0] mode_tab [7] = '{8'h2c, 8'h28, 8'h2d, 8'h29, 8'h2a, 8'h2e, 8'h1e};
  logic [7:0] crtc_tab [3][12] = '{
    '{8'h38, 8'h28, 8'h2d, 8'h0a, 8'h1f, 8'h06, 8'h19, 8'h1c, 8'h02, 8'h07, 8'h06, 8'h07},
    '{8'h71, 8'h50, 8'h5a, 8'h0a, 8'h1f, 8'h06, 8'h19, 8'h1c, 8'h02, 8'h07, 8'h06, 8'h07},
    '{8'h38, 8'h28, 8'h2d, 8'h0a, 8'h7f, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07}};

  always #5 clk = ~clk;

  // CGA status responder: vsync (bit3) rises once vsync_after complete reads have happened.
  assign bus_in = {noise[7:4], (reads_done >= vsync_after), noise[2:0]};

  cga_mode_programmer #(
    .IO_BASE_ADDR(16'h3d0), .STROBE_CYC(STB), .WAIT_VSYNC(1'b1), .POLL_MAX(20'd8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode_sel(mode_sel),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_a(bus_a), .bus_d(bus_d), .bus_in(bus_in),
    .bus_iow_l(bus_iow_l), .bus_ior_l(bus_ior_l), .bus_aen(bus_aen),
    .busy(busy), .done(done), .error(error)
  );

  always @(negedge clk) begin
    cyc++;
    if (bus_req) req_seen = 1;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (!bus_aen && bus_a != 15'h3da && first_wr < 0) first_wr = cyc;
    if (bus_aen && (bus_a != 0 || bus_d != 0 || !bus_iow_l || !bus_ior_l)) bad_idle++;
    if (!bus_iow_l) begin
      if (bus_aen || !bus_ior_l) bad_aen++;
      if (wr_len == 0) begin cur_a = bus_a; cur_d = bus_d; end
      else if (bus_a != cur_a || bus_d != cur_d) bad_hold++;
      wr_len++;
    end else if (wr_len != 0) begin
      if (wr_len == STB) begin
        wr_q.push_back({cur_a, cur_d});
        if (bus_a != cur_a || bus_d != cur_d || bus_aen) bad_hold++;
      end else aborted++;
      wr_len = 0;
    end
    if (!bus_ior_l) begin
      if (bus_aen || bus_a != 15'h3da) bad_aen++;
      rd_len++;
    end else if (rd_len != 0) begin
      if (rd_len == STB) reads_done++; else aborted++;
      rd_len = 0;
    end
  end

  task automatic clr_mon();
    wr_q.delete();
    aborted = 0; reads_done = 0; done_cnt = 0; done_cyc = 0; first_wr = -1;
    bad_aen = 0; bad_idle = 0; bad_hold = 0; req_seen = 0; wr_len = 0; rd_len = 0;
  endtask

  task automatic build_exp(input int m);
    exp_q.delete();
    exp_q.push_back({15'h3d8, mode_tab[m] & 8'hf7});
    for (int r = 0; r < 16; r++) begin
      exp_q.push_back({15'h3d4, 8'(r)});
      exp_q.push_back({15'h3d5, (r < 12) ? crtc_tab[(m < 2) ? 0 : (m < 4) ? 1 : 2][r] : 8'h00});
    end
    exp_q.push_back({15'h3d9, (m == 6) ? 8'h3f : 8'h30});
    exp_q.push_back({15'h3d8, mode_tab[m]});
  endtask

  function automatic int wr_mismatch();
    int n = 0;
    if (wr_q.size() != exp_q.size()) return 1000 + wr_q.size();
    foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic pulse_start(input logic [2:0] m);
    @(negedge clk); #1;
    clr_mon();
    noise = 8'($urandom);
    mode_sel = m; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt > 0) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_drop(input int k, input int j, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (wr_q.size() == k && wr_len == j) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode_sel = 3'd0; bus_gnt = 1'b1; noise = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({bus_req, busy, done, error} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctl: got %b expected 0000", {bus_req, busy, done, error}); end
    checks++; if ({bus_iow_l, bus_ior_l, bus_aen} !== 3'b111) begin errors++;
      $display("FAIL reset_strobes: got %b expected 111", {bus_iow_l, bus_ior_l, bus_aen}); end
    checks++; if (bus_a !== 15'h0 || bus_d !== 8'h0) begin errors++;
      $display("FAIL reset_bus: got a=%h d=%h expected 0 0", bus_a, bus_d); end
    reset = 1'b0;
  endtask

  task automatic test_mode3_latency();
    bit ok;
    vsync_after = 0; build_exp(3);
    pulse_start(3'd3);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL m3_done: got timeout expected done"); end
    checks++; if (wr_mismatch() != 0) begin errors++;
      $display("FAIL m3_writes: got %0d mismatches expected 0", wr_mismatch()); end
    checks++; if (done_cyc - first_wr != 35 * (STB + 2)) begin errors++;
      $display("FAIL m3_latency: got %0d expected %0d", done_cyc - first_wr, 35 * (STB + 2)); end
    checks++; if (reads_done != 1 || error !== 1'b0) begin errors++;
      $display("FAIL m3_poll: got reads=%0d err=%b expected 1 0", reads_done, error); end
    checks++; if (aborted + bad_aen + bad_idle + bad_hold != 0) begin errors++;
      $display("FAIL m3_protocol: got ab=%0d aen=%0d idle=%0d hold=%0d expected 0", aborted, bad_aen, bad_idle, bad_hold); end
    checks++; if (done_cnt != 1 || busy !== 1'b0 || bus_req !== 1'b0) begin errors++;
      $display("FAIL m3_end: got done_cnt=%0d busy=%b req=%b expected 1 0 0", done_cnt, busy, bus_req); end
  endtask

  task automatic test_mode6();
    bit ok;
    vsync_after = 0; build_exp(6);
    pulse_start(3'd6);
    wait_done(ok);
    checks++; if (!ok || wr_mismatch() != 0) begin errors++;
      $display("FAIL m6_writes: got ok=%0d mism=%0d expected 1 0", ok, wr_mismatch()); end
    checks++; if (aborted != 0 || bad_hold != 0) begin errors++;
      $display("FAIL m6_strobe_len: got ab=%0d hold=%0d expected 0 0", aborted, bad_hold); end
  endtask

  task automatic test_vsync_poll();
    bit ok;
    vsync_after = 3; build_exp(0);
    pulse_start(3'd0);
    wait_done(ok);
    checks++; if (!ok || reads_done != 4) begin errors++;
      $display("FAIL poll_reads: got ok=%0d reads=%0d expected 1 4", ok, reads_done); end
    checks++; if (error !== 1'b0 || wr_mismatch() != 0) begin errors++;
      $display("FAIL poll_writes: got err=%b mism=%0d expected 0 0", error, wr_mismatch()); end
  endtask

  task automatic test_poll_timeout();
    bit ok;
    vsync_after = 1000; build_exp(5);
    pulse_start(3'd5);
    wait_done(ok);
    checks++; if (!ok || reads_done != 8) begin errors++;
      $display("FAIL tmo_reads: got ok=%0d reads=%0d expected 1 8", ok, reads_done); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b expected 1", error); end
    checks++; if (wr_mismatch() != 0 || done_cnt != 1) begin errors++;
      $display("FAIL tmo_writes: got mism=%0d done=%0d expected 0 1", wr_mismatch(), done_cnt); end
  endtask

  task automatic test_invalid();
    pulse_start(3'd7);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_seen != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL inv_req: got req=%0d busy=%b expected 0 0", req_seen, busy); end
    checks++; if (error !== 1'b1 || done_cnt != 1) begin errors++;
      $display("FAIL inv_flags: got err=%b done=%0d expected 1 1", error, done_cnt); end
  endtask

  task automatic test_start_busy();
    bit ok;
    vsync_after = 0; build_exp(2);
    pulse_start(3'd2);
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL sb_accept: got err=%b busy=%b expected 0 1", error, busy); end
    repeat (40) @(negedge clk);
    #1; mode_sel = 3'd5; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    wait_done(ok);
    checks++; if (!ok || wr_mismatch() != 0 || done_cnt != 1) begin errors++;
      $display("FAIL sb_ignore: got ok=%0d mism=%0d done=%0d expected 1 0 1", ok, wr_mismatch(), done_cnt); end
  endtask

  task automatic test_gnt_drop();
    bit ok, found;
    vsync_after = 0; build_exp(1);
    pulse_start(3'd1);
    wait_drop(10, 2, found);
    bus_gnt = 1'b0;
    @(negedge clk); #1;
    checks++; if (!found || {bus_iow_l, bus_ior_l, bus_aen} !== 3'b111 || bus_a !== 0 || bus_d !== 0) begin errors++;
      $display("FAIL drop_release: got found=%0d strb=%b a=%h d=%h expected 1 111 0 0",
               found, {bus_iow_l, bus_ior_l, bus_aen}, bus_a, bus_d); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (bus_req !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL drop_req: got req=%b busy=%b expected 1 1", bus_req, busy); end
    bus_gnt = 1'b1;
    wait_done(ok);
    checks++; if (!ok || wr_mismatch() != 0 || aborted != 1) begin errors++;
      $display("FAIL drop_writes: got ok=%0d mism=%0d ab=%0d expected 1 0 1", ok, wr_mismatch(), aborted); end
  endtask

  task automatic test_random();
    bit ok, found;
    int m, dly, k, j;
    for (int it = 0; it < 5; it++) begin
      m = $urandom_range(0, 6); dly = $urandom_range(1, 6);
      k = $urandom_range(0, 34); j = $urandom_range(1, STB - 1);
      vsync_after = $urandom_range(0, 2); build_exp(m);
      bus_gnt = 1'b0;
      pulse_start(3'(m));
      repeat (dly) @(negedge clk);
      #1;
      checks++; if (bus_req !== 1'b1 || bus_aen !== 1'b1) begin errors++;
        $display("FAIL rnd_wait_gnt it%0d: got req=%b aen=%b expected 1 1", it, bus_req, bus_aen); end
      bus_gnt = 1'b1;
      wait_drop(k, j, found);
      bus_gnt = 1'b0;
      repeat (2) @(negedge clk);
      #1; bus_gnt = 1'b1;
      wait_done(ok);
      checks++; if (!found || !ok || wr_mismatch() != 0 || aborted != 1) begin errors++;
        $display("FAIL rnd_seq it%0d m=%0d: got f=%0d ok=%0d mism=%0d ab=%0d expected 1 1 0 1",
                 it, m, found, ok, wr_mismatch(), aborted); end
      checks++; if (reads_done != vsync_after + 1 || error !== 1'b0 || bad_idle + bad_aen + bad_hold != 0) begin errors++;
        $display("FAIL rnd_poll it%0d: got reads=%0d err=%b bad=%0d expected %0d 0 0",
                 it, reads_done, error, bad_idle + bad_aen + bad_hold, vsync_after + 1); end
    end
  endtask

  task automatic test_reset_mid();
    vsync_after = 0;
    pulse_start(3'd4);
    repeat (60) @(negedge clk);
    #3; reset = 1'b1;
    #1;
    checks++; if ({bus_req, busy, done, error, bus_iow_l, bus_ior_l, bus_aen} !== 7'b0000111 || bus_a !== 0 || bus_d !== 0) begin errors++;
      $display("FAIL rst_mid: got ctl=%b a=%h d=%h expected 0000111 0 0",
               {bus_req, busy, done, error, bus_iow_l, bus_ior_l, bus_aen}, bus_a, bus_d); end
    @(negedge clk); #1; reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (bus_req !== 1'b0 || bus_aen !== 1'b1) begin errors++;
      $display("FAIL rst_idle: got req=%b aen=%b expected 0 1", bus_req, bus_aen); end
  endtask

  initial begin
    test_reset();
    test_mode3_latency();
    test_mode6();
    test_vsync_poll();
    test_poll_timeout();
    test_invalid();
    test_start_busy();
    test_gnt_drop();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
